// File: rtl/aer_event_packetizer.sv
// AER event packetizer: timestamps polarity-filtered pixel events and queues
// them as {timestamp, x, y, polarity} in a first-word-fall-through FIFO.
module aer_event_packetizer #(
    parameter int ROW_ADD  = 4,
    parameter int COL_ADD  = 4,
    parameter int SIZE     = 16,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 1,
    parameter int DROP_W   = 8,
    localparam int WIDTH   = SIZE + ROW_ADD + COL_ADD + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [1:0]               pol_en_i,
    input  logic [ROW_ADD-1:0]       x_add_i,
    input  logic [COL_ADD-1:0]       y_add_i,
    input  logic                     polarity_i,
    input  logic                     event_valid_i,
    output logic                     event_ready_o,
    output logic [WIDTH-1:0]         data_out_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic [SIZE-1:0]          timestamp_o,
    output logic [$clog2(DEPTH):0]   fill_level_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] PRE_TC   = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [SIZE-1:0]   ts_q, ts_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       lvl_q, lvl_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic full, empty, qualified, push, pop, drop, tick;

    always_comb begin
        full      = (lvl_q == FULL_LVL);
        empty     = (lvl_q == '0);
        qualified = event_valid_i & enable_i & pol_en_i[polarity_i];
        // A full FIFO blocks the push even when a pop frees a slot this cycle.
        push      = qualified & ~full;
        drop      = qualified & full;
        pop       = ~empty & data_ready_i;
        tick      = enable_i && (presc_q == PRE_TC);

        presc_d = presc_q;
        ts_d    = ts_q;
        if (enable_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) ts_d = ts_q + 1'b1;
        end

        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop  ? rd_q + 1'b1 : rd_q;
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
        endcase

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clear_i) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
            ts_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            presc_q <= presc_d;
            ts_q    <= ts_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) mem_q[wr_q] <= {ts_q, x_add_i, y_add_i, polarity_i};
    end

    assign event_ready_o = ~full;
    assign data_valid_o  = ~empty;
    assign data_out_o    = empty ? '0 : mem_q[rd_q];
    assign timestamp_o   = ts_q;
    assign fill_level_o  = lvl_q;
    assign overflow_o    = ovf_q;
    assign drop_count_o  = drop_q;

endmodule

// File: tb/tb_aer_event_packetizer.sv
// Bench for aer_event_packetizer: two instances (TICK_DIV 1/4, DROP_W 8/2) on shared
// inputs, compared each cycle against a queue-based reference model.
module tb_aer_event_packetizer;

    logic        clk = 1'b0;
    logic        reset, enable, clear, pol, ev_valid, data_ready;
    logic [1:0]  pol_en;
    logic [3:0]  x, y;

    logic        ready_a, valid_a, ovf_a;
    logic [24:0] data_a;
    logic [15:0] ts_a;
    logic [3:0]  fill_a;
    logic [7:0]  drop_a;

    logic        ready_b, valid_b, ovf_b;
    logic [24:0] data_b;
    logic [15:0] ts_b;
    logic [3:0]  fill_b;
    logic [1:0]  drop_b;

    always #5 clk = ~clk;

    aer_event_packetizer #(.DEPTH(8), .TICK_DIV(1), .DROP_W(8)) dut_a (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear),
        .pol_en_i(pol_en), .x_add_i(x), .y_add_i(y), .polarity_i(pol),
        .event_valid_i(ev_valid), .event_ready_o(ready_a), .data_out_o(data_a),
        .data_valid_o(valid_a), .data_ready_i(data_ready), .timestamp_o(ts_a),
        .fill_level_o(fill_a), .overflow_o(ovf_a), .drop_count_o(drop_a)
    );

    aer_event_packetizer #(.DEPTH(8), .TICK_DIV(4), .DROP_W(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear),
        .pol_en_i(pol_en), .x_add_i(x), .y_add_i(y), .polarity_i(pol),
        .event_valid_i(ev_valid), .event_ready_o(ready_b), .data_out_o(data_b),
        .data_valid_o(valid_b), .data_ready_i(data_ready), .timestamp_o(ts_b),
        .fill_level_o(fill_b), .overflow_o(ovf_b), .drop_count_o(drop_b)
    );

    // Reference model: accepted events with the enabled-cycle count at capture;
    // timestamps are derived as count / TICK_DIV for each instance.
    typedef struct {
        int unsigned cnt;
        logic [8:0]  xyp;
    } ev_t;

    ev_t         mq[$];
    int unsigned en_cnt = 0;
    int unsigned drops  = 0;
    bit          movf   = 1'b0;
    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int unsigned lvl;
        lvl = mq.size();
        chk("fill_a",  32'(fill_a),  lvl);
        chk("fill_b",  32'(fill_b),  lvl);
        chk("valid_a", 32'(valid_a), 32'(lvl != 0));
        chk("valid_b", 32'(valid_b), 32'(lvl != 0));
        chk("ready_a", 32'(ready_a), 32'(lvl != 8));
        chk("ready_b", 32'(ready_b), 32'(lvl != 8));
        chk("ts_a",    32'(ts_a),    en_cnt % 65536);
        chk("ts_b",    32'(ts_b),    (en_cnt / 4) % 65536);
        chk("ovf_a",   32'(ovf_a),   32'(movf));
        chk("ovf_b",   32'(ovf_b),   32'(movf));
        chk("drop_a",  32'(drop_a),  (drops > 255) ? 255 : drops);
        chk("drop_b",  32'(drop_b),  (drops > 3) ? 3 : drops);
        if (lvl != 0) begin
            chk("data_a", 32'(data_a), 32'({16'(mq[0].cnt), mq[0].xyp}));
            chk("data_b", 32'(data_b), 32'({16'(mq[0].cnt / 4), mq[0].xyp}));
        end
    endtask

    // One clock: model decisions use pre-edge state, checks run 1 time unit after.
    task automatic cycle();
        bit  qual, mfull, mpop;
        ev_t e;
        qual  = ev_valid && enable && pol_en[pol];
        mfull = (mq.size() == 8);
        mpop  = (mq.size() != 0) && data_ready;
        e.cnt = en_cnt;
        e.xyp = {x, y, pol};
        @(posedge clk);
        if (reset) begin
            mq.delete();
            en_cnt = 0;
            drops  = 0;
            movf   = 1'b0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (qual && !mfull) mq.push_back(e);
            if (clear) begin
                drops = 0;
                movf  = 1'b0;
            end else if (qual && mfull) begin
                drops++;
                movf = 1'b1;
            end
            if (enable) en_cnt++;
        end
        #1;
        check_all();
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; pol_en = 2'b11;
        x = '0; y = '0; pol = 1'b0; ev_valid = 1'b0; data_ready = 1'b0;

        // Reset state
        cycles(2);
        reset = 1'b0;
        chk("rst_ready", 32'(ready_a), 1);
        chk("rst_fill",  32'(fill_a),  0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_ts",    32'(ts_a),    0);

        // First event, captured at timestamp 4, visible one cycle later
        enable = 1'b1;
        cycles(4);
        chk("ts_before_push", 32'(ts_a), 4);
        x = 4'd3; y = 4'd5; pol = 1'b1; ev_valid = 1'b1;
        chk("no_bypass", 32'(valid_a), 0);
        cycle();
        ev_valid = 1'b0;
        chk("first_data",  32'(data_a), 32'({16'h0004, 4'h3, 4'h5, 1'b1}));
        chk("first_valid", 32'(valid_a), 1);
        chk("first_fill",  32'(fill_a), 1);
        data_ready = 1'b1;
        cycle();
        data_ready = 1'b0;

        // Prescaler by 4 and hold while disabled
        do_reset();
        enable = 1'b1;
        cycles(16);
        chk("ts_div4", 32'(ts_b), 4);
        enable = 1'b0; ev_valid = 1'b1;
        cycles(10);
        ev_valid = 1'b0;
        chk("ts_hold",      32'(ts_b),   4);
        chk("disabled_ign", 32'(fill_b), 0);

        // Overflow, pop-does-not-rescue, clear priority
        do_reset();
        enable = 1'b1; ev_valid = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            x = 4'(i); y = 4'(15 - i); pol = i[0];
            cycle();
        end
        chk("ovf_fill",  32'(fill_a),  8);
        chk("ovf_ready", 32'(ready_a), 0);
        chk("ovf_drops", 32'(drop_a),  2);
        chk("ovf_flag",  32'(ovf_a),   1);
        data_ready = 1'b1;
        cycle();
        data_ready = 1'b0;
        chk("no_rescue_fill", 32'(fill_a), 7);
        chk("no_rescue_drop", 32'(drop_a), 3);
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0; ev_valid = 1'b0;
        chk("clear_drop", 32'(drop_a), 0);
        chk("clear_ovf",  32'(ovf_a),  0);

        // Drop counter saturation with DROP_W=2
        ev_valid = 1'b1;
        cycles(6);
        ev_valid = 1'b0;
        chk("sat_b", 32'(drop_b), 3);
        chk("sat_a", 32'(drop_a), 6);

        // Polarity filter: only OFF events accepted
        do_reset();
        pol_en = 2'b01; ev_valid = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            x = 4'(i + 1); pol = i[0];
            cycle();
        end
        ev_valid = 1'b0;
        chk("pol_fill", 32'(fill_a), 3);
        chk("pol_drop", 32'(drop_a), 0);
        data_ready = 1'b1;
        cycles(4);
        data_ready = 1'b0;

        // Steady push+pop at level 3, wrapping the pointers
        do_reset();
        pol_en = 2'b11; ev_valid = 1'b1;
        cycles(3);
        data_ready = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            x = 4'($urandom); y = 4'($urandom); pol = 1'($urandom);
            cycle();
        end
        chk("steady_fill", 32'(fill_a), 3);

        // Reset with buffered events
        data_ready = 1'b0;
        cycles(2);
        ev_valid = 1'b0;
        chk("pre_reset_fill", 32'(fill_a), 5);
        do_reset();
        chk("mid_rst_fill",  32'(fill_a),  0);
        chk("mid_rst_valid", 32'(valid_a), 0);
        chk("mid_rst_ts",    32'(ts_a),    0);
        chk("mid_rst_ready", 32'(ready_a), 1);

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            ev_valid   = 1'($urandom);
            data_ready = ($urandom_range(0, 2) == 0);
            pol_en     = 2'($urandom);
            clear      = ($urandom_range(0, 29) == 0);
            x = 4'($urandom); y = 4'($urandom); pol = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aer_event_packetizer.md
Name: aer_event_packetizer

Overview:
- Parametrised successor to the combinational AER event packer.
- Accepts pixel events (row, column, polarity) from the arbiter through a valid/ready handshake, and timestamps them with an internal free-running counter with prescaler.
- Filters events by polarity, packs each one as {timestamp, x, y, polarity}, and buffers it in a first-word-fall-through FIFO ahead of the readout interface.
- Tracks buffer overflow with a sticky flag and a saturating drop counter.

Parameters:
- ROW_ADD, 4, row address width
- COL_ADD, 4, column address width
- SIZE, 16, timestamp width
- DEPTH, 8, FIFO depth in events; power of two, ≥2
- TICK_DIV, 1, clk_i cycles per timestamp increment; ≥1
- DROP_W, 8, drop counter width
- WIDTH, SIZE+ROW_ADD+COL_ADD+1, packed event width; derived, not overridden

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- enable_i  in  1  runs the timestamp counter and allows event capture
- clear_i  in  1  clears overflow_o and drop_count_o
- pol_en_i  in  2  bit0 accepts polarity 0 (OFF); bit1 accepts polarity 1 (ON)
- x_add_i  in  ROW_ADD  event row address
- y_add_i  in  COL_ADD  event column address
- polarity_i  in  1  event polarity
- event_valid_i  in  1  event present
- event_ready_o  out  1  packetizer can accept an event
- data_out_o  out  WIDTH  head event {timestamp, x, y, polarity}
- data_valid_o  out  1  data_out_o holds a valid event
- data_ready_i  in  1  consumer takes the head event
- timestamp_o  out  SIZE  current timestamp
- fill_level_o  out  $clog2(DEPTH)+1  events stored
- overflow_o  out  1  sticky: at least one event dropped
- drop_count_o  out  DROP_W  dropped events, saturating

Behaviour:
- Reset: applies on the clk_i edge while reset_i=1.
  - All outputs go to 0, except event_ready_o=1.
  - FIFO is emptied, prescaler and timestamp go to 0.
  - Reset mid-operation discards all buffered events.
- Timestamp:
  - Prescaler counts 0..TICK_DIV-1 while enable_i=1.
  - timestamp_o increments on prescaler terminal count and wraps from 2^SIZE-1 to 0. No wrap event is generated.
  - When enable_i=0, prescaler and timestamp hold.
- Qualified event: event_valid_i=1 AND enable_i=1 AND pol_en_i[polarity_i]=1.
  - Unqualified events are ignored silently: not stored, not counted.
- event_ready_o = !full. It is independent of event_valid_i and data_ready_i.
- Push: qualified event AND not full.
  - Stores {timestamp_o, x_add_i, y_add_i, polarity_i} using the timestamp value present in the capture cycle.
- Drop: qualified event AND full.
  - overflow_o is set; drop_count_o increments and saturates at 2^DROP_W-1.
  - A pop in the same cycle does not rescue the event; a full FIFO always blocks the push.
- clear_i:
  - Zeroes overflow_o and drop_count_o on the next edge.
  - Has priority over a same-cycle drop; that drop is not counted.
- Pop: data_valid_o=1 AND data_ready_i=1. The head advances on the edge.
- data_valid_o = !empty. data_out_o is the FIFO head; its value is don't-care when empty.
- Latency:
  - An event pushed at edge N into an empty FIFO gives data_valid_o=1 in the cycle after edge N.
  - There is no same-cycle combinational bypass.
- Simultaneous push and pop with 0<level<DEPTH: fill_level_o unchanged, ordering preserved.
- Push with FIFO empty and data_ready_i=1: no pop that cycle; the event appears next cycle.
- Pointers use log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from fill_level_o (DEPTH / 0).
- Readout continues while enable_i=0.
- Output order is strictly FIFO order of acceptance.

Test Plan:
- Reset, then enable_i=1, TICK_DIV=1, pol_en_i=2'b11. Push x=3, y=5, pol=1 with timestamp_o=0x0004 → data_out_o=0x0004_3_5_1 (25'h000 4 3 5 1 packing) valid one cycle later, fill_level_o=1.
- TICK_DIV=4, enable_i=1 for 16 cycles → timestamp_o=4. Drop enable_i for 10 cycles → timestamp_o holds 4 and events are ignored.
- data_ready_i=0, 10 qualified events with DEPTH=8 → fill_level_o=8, event_ready_o=0, drop_count_o=2, overflow_o=1. Then pulse clear_i → both 0.
- pol_en_i=2'b01, alternate pol 0/1 over 6 events → only 3 polarity-0 events stored, drop_count_o=0.
- Steady push+pop every cycle at fill_level_o=3 for 20 cycles → level stays 3, output order matches input order, pointers wrap correctly.
- Assert reset_i with 5 events buffered → next cycle fill_level_o=0, data_valid_o=0, timestamp_o=0, event_ready_o=1.
- Drop counter with DROP_W=2, 6 drops → drop_count_o saturates at 3.
